// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state
// encoding, the all-bytes enable constant and default bus widths.
package mips_mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data requesters, the arbiter and the
// single-ported memory. The arbiter takes the slave view; the environment
// (core + memory) takes the master view.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_we;
  logic [3:0]    d_re;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_write;
  logic [3:0]    mem_read;
  logic [DW-1:0] mem_rdata;

  logic          grant_d;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_we, d_re, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
           mem_addr, mem_wdata, mem_write, mem_read, grant_d
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_we, d_re, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
           mem_addr, mem_wdata, mem_write, mem_read, grant_d
  );

endinterface

// File: rtl/wait_counter.sv
// 4-bit loadable down-counter with a zero flag; counts the wait cycles of
// one memory transaction and parks at zero.
module wait_counter (
  input  logic       clk,
  input  logic       nrst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  // Load has precedence; decrement stops at zero rather than wrapping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's instruction-fetch and data requesters onto one
// single-ported memory. Each access is a fixed LAT-cycle transaction
// followed by a one-cycle acknowledge. Data wins ties unless fetch has been
// passed over MAX_DSTREAK times in a row.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int LAT         = 2,
  parameter int MAX_DSTREAK = 4
) (
  input logic                clk,
  input logic                nrst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] LAT_M1  = 4'(LAT - 1);
  localparam logic [3:0] DSTK_MX = 4'(MAX_DSTREAK);

  state_e        state;
  state_e        state_nxt;
  logic [3:0]    dstreak;
  logic          gnt_d;
  logic          grant;
  logic          pick_d;
  logic          cnt_zero;
  logic          last_busy;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    we_q;
  logic [3:0]    re_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // Arbitration happens only in IDLE; fetch wins once data has had its streak.
  always_comb begin
    pick_d = bus.d_req && !(bus.if_req && (dstreak == DSTK_MX));
    grant  = (state == IDLE) && (bus.if_req || bus.d_req);
  end

  assign last_busy = (state == BUSY) && cnt_zero;

  wait_counter u_wait (
    .clk      (clk),
    .nrst     (nrst),
    .load     (grant),
    .load_val (LAT_M1),
    .dec      (state == BUSY),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: requests are only looked at in IDLE, DONE always retires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: who owns the port and how long data has been winning.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gnt_d   <= 1'b0;
      dstreak <= 4'd0;
    end else if (grant) begin
      gnt_d <= pick_d;
      if (!pick_d) begin
        dstreak <= 4'd0;
      end else if (dstreak != DSTK_MX) begin
        dstreak <= dstreak + 4'd1;
      end
    end
  end

  // Capture the winner's request so mid-transaction input changes are ignored;
  // a fetch is recorded as a full-word read with no write strobes.
  always_ff @(posedge clk) begin
    if (grant) begin
      if (pick_d) begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        we_q    <= bus.d_we;
        re_q    <= bus.d_re;
      end else begin
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
        we_q    <= 4'h0;
        re_q    <= BYTE_EN_ALL;
      end
    end
  end

  // Read data returns on the last BUSY edge into the granted requester's register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (last_busy) begin
      if (gnt_d) begin
        d_rdata_q <= bus.mem_rdata;
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Memory drive: active only in BUSY; the write strobe fires once, on the last cycle.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 4'h0;
    bus.mem_write = 4'h0;
    if (state == BUSY) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_read  = re_q;
      if (cnt_zero) bus.mem_write = we_q;
    end
  end

  assign bus.if_ack   = (state == DONE) && !gnt_d;
  assign bus.d_ack    = (state == DONE) && gnt_d;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.grant_d  = gnt_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=2 instance driven through a scoreboard
// of expected acknowledges, plus a LAT=1 instance for the single-cycle case.
module tb_mem_port_arbiter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) c ();

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .MAX_DSTREAK(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (b)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .MAX_DSTREAK(4)) dut_l1 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (c)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2010_0005;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign b.mem_rdata = memval(b.mem_addr);
  assign c.mem_rdata = memval(c.mem_addr);

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        chk_val;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  task automatic expect_ack(input logic is_d, input logic chk_val, input logic [31:0] val);
    exp_t e;
    e.is_d = is_d; e.chk_val = chk_val; e.val = val;
    sbq.push_back(e);
  endtask

  // Every acknowledge on the LAT=2 instance is matched against the scoreboard.
  always @(negedge clk) begin
    if (b.if_ack || b.d_ack) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {30'd0, b.d_ack, b.if_ack}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ack_source", {31'd0, b.d_ack}, {31'd0, e.is_d});
        chk("ack_exclusive", {31'd0, b.if_ack & b.d_ack}, 32'd0);
        if (e.chk_val) begin
          if (e.is_d) chk("d_rdata", b.d_rdata, e.val);
          else        chk("if_rdata", b.if_rdata, e.val);
        end
      end
    end
  end

  task automatic d_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic [3:0] re, input bit hold, output int ack_cyc);
    int n;
    bit got;
    b.d_req = 1'b1; b.d_addr = a; b.d_wdata = wd; b.d_we = we; b.d_re = re;
    n = 0; got = 1'b0; ack_cyc = -1;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      got = b.d_ack;
    end
    if (got) ack_cyc = cyc;
    else chk("d_ack_timeout", 32'd0, 32'd1);
    if (!hold) b.d_req = 1'b0;
  endtask

  task automatic f_txn(input logic [31:0] a, input bit hold, output int ack_cyc);
    int n;
    bit got;
    b.if_req = 1'b1; b.if_addr = a;
    n = 0; got = 1'b0; ack_cyc = -1;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      got = b.if_ack;
    end
    if (got) ack_cyc = cyc;
    else chk("if_ack_timeout", 32'd0, 32'd1);
    if (!hold) b.if_req = 1'b0;
  endtask

  int td, ti, tdum;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_addr = 0; b.d_wdata = 0; b.d_we = 0; b.d_re = 0;
    c.if_req = 0; c.if_addr = 0; c.d_req = 0; c.d_addr = 0; c.d_wdata = 0; c.d_we = 0; c.d_re = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_if_ack", {31'd0, b.if_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, b.d_ack}, 32'd0);
    chk("rst_grant_d", {31'd0, b.grant_d}, 32'd0);
    chk("rst_mem_read", {28'd0, b.mem_read}, 32'd0);
    chk("rst_if_rdata", b.if_rdata, 32'd0);
    chk("rst_d_rdata", b.d_rdata, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Fetch only, cycle by cycle
    expect_ack(1'b0, 1'b1, 32'h2010_0005);
    b.if_req = 1'b1; b.if_addr = 32'h40;
    @(negedge clk);
    chk("f_c1_mem_read", {28'd0, b.mem_read}, 32'hF);
    chk("f_c1_mem_addr", b.mem_addr, 32'h40);
    chk("f_c1_if_ack", {31'd0, b.if_ack}, 32'd0);
    @(negedge clk);
    chk("f_c2_mem_read", {28'd0, b.mem_read}, 32'hF);
    chk("f_c2_mem_write", {28'd0, b.mem_write}, 32'd0);
    chk("f_c2_if_ack", {31'd0, b.if_ack}, 32'd0);
    @(negedge clk);
    chk("f_c3_if_ack", {31'd0, b.if_ack}, 32'd1);
    chk("f_c3_d_ack", {31'd0, b.d_ack}, 32'd0);
    chk("f_c3_mem_read", {28'd0, b.mem_read}, 32'd0);
    chk("f_c3_mem_addr", b.mem_addr, 32'd0);
    chk("f_grant_d", {31'd0, b.grant_d}, 32'd0);
    b.if_req = 1'b0;
    @(negedge clk);

    // Data store, cycle by cycle
    expect_ack(1'b1, 1'b0, 32'd0);
    b.d_req = 1'b1; b.d_addr = 32'h100; b.d_wdata = 32'hDEAD_BEEF; b.d_we = 4'b0011; b.d_re = 4'h0;
    @(negedge clk);
    chk("s_c1_mem_write", {28'd0, b.mem_write}, 32'd0);
    chk("s_c1_mem_addr", b.mem_addr, 32'h100);
    chk("s_c1_mem_read", {28'd0, b.mem_read}, 32'd0);
    @(negedge clk);
    chk("s_c2_mem_write", {28'd0, b.mem_write}, 32'h3);
    chk("s_c2_mem_addr", b.mem_addr, 32'h100);
    chk("s_c2_mem_wdata", b.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("s_c3_d_ack", {31'd0, b.d_ack}, 32'd1);
    chk("s_c3_mem_write", {28'd0, b.mem_write}, 32'd0);
    chk("s_grant_d", {31'd0, b.grant_d}, 32'd1);
    b.d_req = 1'b0;
    @(negedge clk);
    chk("s_c4_d_ack", {31'd0, b.d_ack}, 32'd0);

    // Data load and a plain fetch through the scoreboard
    expect_ack(1'b1, 1'b1, memval(32'h200));
    d_txn(32'h200, 32'd0, 4'h0, 4'hF, 1'b0, tdum);
    expect_ack(1'b0, 1'b1, memval(32'h44));
    f_txn(32'h44, 1'b0, tdum);
    chk("if_rdata_hold", b.if_rdata, memval(32'h44));
    @(negedge clk);

    // Simultaneous requests with dstreak at zero: data first, fetch LAT+2 later
    expect_ack(1'b1, 1'b1, memval(32'h300));
    expect_ack(1'b0, 1'b1, memval(32'h48));
    fork
      d_txn(32'h300, 32'd0, 4'h0, 4'hF, 1'b0, td);
      f_txn(32'h48, 1'b0, ti);
    join
    chk("simul_ack_spacing", 32'(ti - td), 32'd4);
    @(negedge clk);

    // Starvation: D,D,D,D,I,D,D,D,D,I,D
    for (int k = 0; k < 4; k++) expect_ack(1'b1, 1'b1, memval(32'h400 + 32'(4 * k)));
    expect_ack(1'b0, 1'b1, memval(32'h80));
    for (int k = 4; k < 8; k++) expect_ack(1'b1, 1'b1, memval(32'h400 + 32'(4 * k)));
    expect_ack(1'b0, 1'b1, memval(32'h84));
    expect_ack(1'b1, 1'b1, memval(32'h420));
    fork
      begin
        int tdd;
        for (int k = 0; k < 9; k++) d_txn(32'h400 + 32'(4 * k), 32'd0, 4'h0, 4'hF, k < 8, tdd);
      end
      begin
        int tff;
        f_txn(32'h80, 1'b1, tff);
        f_txn(32'h84, 1'b0, tff);
      end
    join
    @(negedge clk);

    // Request dropped and address changed mid-transaction: latched values win
    expect_ack(1'b1, 1'b1, memval(32'h700));
    b.d_req = 1'b1; b.d_addr = 32'h700; b.d_we = 4'h0; b.d_re = 4'hF;
    @(negedge clk);
    b.d_req = 1'b0; b.d_addr = 32'h7F0;
    @(negedge clk);
    chk("viol_mem_addr", b.mem_addr, 32'h700);
    @(negedge clk);
    chk("viol_d_ack", {31'd0, b.d_ack}, 32'd1);
    @(negedge clk);

    // Reset in the first BUSY cycle aborts without ack
    b.d_req = 1'b1; b.d_addr = 32'h500; b.d_we = 4'h0; b.d_re = 4'hF;
    @(negedge clk);
    chk("rb_busy_read", {28'd0, b.mem_read}, 32'hF);
    nrst = 1'b0;
    #1;
    chk("rb_mem_read", {28'd0, b.mem_read}, 32'd0);
    chk("rb_mem_addr", b.mem_addr, 32'd0);
    chk("rb_d_rdata", b.d_rdata, 32'd0);
    chk("rb_if_rdata", b.if_rdata, 32'd0);
    chk("rb_grant_d", {31'd0, b.grant_d}, 32'd0);
    @(negedge clk);
    chk("rb_held_d_ack", {31'd0, b.d_ack}, 32'd0);
    nrst = 1'b1;
    expect_ack(1'b1, 1'b1, memval(32'h500));
    begin
      int n;
      n = 0;
      while (!b.d_ack && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rb_fresh_latency", 32'(n), 32'd3);
    end
    b.d_req = 1'b0;
    @(negedge clk);

    // LAT=1 instance: write and read in the single BUSY cycle, ack 2 cycles later
    c.d_req = 1'b1; c.d_addr = 32'h600; c.d_wdata = 32'h1234_5678; c.d_we = 4'hF; c.d_re = 4'hF;
    @(negedge clk);
    chk("l1_mem_write", {28'd0, c.mem_write}, 32'hF);
    chk("l1_mem_read", {28'd0, c.mem_read}, 32'hF);
    chk("l1_mem_addr", c.mem_addr, 32'h600);
    chk("l1_mem_wdata", c.mem_wdata, 32'h1234_5678);
    chk("l1_c1_d_ack", {31'd0, c.d_ack}, 32'd0);
    @(negedge clk);
    chk("l1_c2_d_ack", {31'd0, c.d_ack}, 32'd1);
    chk("l1_d_rdata", c.d_rdata, memval(32'h600));
    chk("l1_c2_mem_write", {28'd0, c.mem_write}, 32'd0);
    c.d_req = 1'b0;
    @(negedge clk);
    chk("l1_c3_d_ack", {31'd0, c.d_ack}, 32'd0);
    c.if_req = 1'b1; c.if_addr = 32'h40;
    @(negedge clk);
    chk("l1_f_c1_if_ack", {31'd0, c.if_ack}, 32'd0);
    @(negedge clk);
    chk("l1_f_c2_if_ack", {31'd0, c.if_ack}, 32'd1);
    chk("l1_if_rdata", c.if_rdata, 32'h2010_0005);
    c.if_req = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
